dec_mult_seq_ctrl: RTL and testbench

Sequential BCD multiplier controller and datapath. It multiplies an NDIG-digit BCD multiplicand A by an NDIG-digit BCD multiplier B and returns a 2*NDIG-digit BCD product.
- Method: iterative shift-and-add, processing B most-significant digit first.
- Purpose: low-area alternative and golden sequencer alongside the parallel 4221-redundant product path.
- Interfaces: valid/ready on both input and output, so it can share the operand bus with the parallel multiplier.

---
 rtl/dec_mult_pkg.sv | 12 +
 rtl/dec_mult_seq_ctrl_if.sv | 22 ++
 rtl/dec_mult_seq_ctrl_bcd_digit_add.sv | 18 +
 rtl/dec_mult_seq_ctrl.sv | 103 ++++++++++
 tb/tb_dec_mult_seq_ctrl.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dec_mult_pkg.sv
// dec_mult_pkg: shared types, constants and digit checks for the sequential BCD multiplier
package dec_mult_pkg;
    localparam int NDIG_DEFAULT = 4;
    localparam int DIG_W = 4;
    localparam logic [DIG_W-1:0] BCD_CORR = 4'd6;

    typedef enum logic [1:0] {IDLE, SHIFT, ADD, DONE} state_t;

    function automatic logic bad_digit(input logic [DIG_W-1:0] d);
        return d > 4'd9;
    endfunction
endpackage

// File: rtl/dec_mult_seq_ctrl_if.sv
// dec_mult_seq_ctrl_if: operand/product valid-ready bus of the sequential BCD multiplier
interface dec_mult_seq_ctrl_if #(parameter int NDIG = dec_mult_pkg::NDIG_DEFAULT);
    logic              in_valid;
    logic              in_ready;
    logic [4*NDIG-1:0] a_bcd;
    logic [4*NDIG-1:0] b_bcd;
    logic              out_valid;
    logic              out_ready;
    logic [8*NDIG-1:0] p_bcd;
    logic              err;
    logic              busy;

    modport master (
        output in_valid, a_bcd, b_bcd, out_ready,
        input  in_ready, out_valid, p_bcd, err, busy
    );

    modport slave (
        input  in_valid, a_bcd, b_bcd, out_ready,
        output in_ready, out_valid, p_bcd, err, busy
    );
endinterface

// File: rtl/dec_mult_seq_ctrl_bcd_digit_add.sv
// bcd_digit_add: one BCD digit adder with carry in/out, +6 correction on decimal overflow
module bcd_digit_add
    import dec_mult_pkg::*;
(
    input  logic [DIG_W-1:0] a,
    input  logic [DIG_W-1:0] b,
    input  logic             ci,
    output logic [DIG_W-1:0] s,
    output logic             co
);
    logic [DIG_W:0] raw;

    always_comb begin
        raw = {1'b0, a} + {1'b0, b} + {{DIG_W{1'b0}}, ci};
        co  = raw > 5'd9;
        s   = co ? raw[DIG_W-1:0] + BCD_CORR : raw[DIG_W-1:0];
    end
endmodule

// File: rtl/dec_mult_seq_ctrl.sv
// dec_mult_seq_ctrl: shift-and-add BCD multiplier, multiplier digits consumed MSD first,
// one ADD cycle per unit of the current multiplier digit.
module dec_mult_seq_ctrl
    import dec_mult_pkg::*;
#(
    parameter int NDIG = NDIG_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    dec_mult_seq_ctrl_if.slave bus
);
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;
    localparam int PW = 8 * NDIG;

    state_t            state, nxt;
    logic [4*NDIG-1:0] a_q, b_q;
    logic [PW-1:0]     acc, sum;
    logic [PW-1:0]     a_ext;
    logic [2*NDIG:0]   cy;
    logic              cy_top;
    logic [DIG_W-1:0]  rep, cur_dig;
    logic [IW-1:0]     dig_idx;
    logic              err_q, in_bad, last_dig;

    always_comb begin
        in_bad = 1'b0;
        for (int k = 0; k < NDIG; k++)
            in_bad = in_bad | bad_digit(bus.a_bcd[4*k +: 4]) | bad_digit(bus.b_bcd[4*k +: 4]);
    end

    assign a_ext    = {{(4*NDIG){1'b0}}, a_q};
    assign cur_dig  = b_q[4*dig_idx +: 4];
    assign last_dig = dig_idx == '0;
    assign cy[0]    = 1'b0;
    assign cy_top   = cy[2*NDIG];

    for (genvar g = 0; g < 2*NDIG; g++) begin : g_add
        bcd_digit_add u_dig (
            .a  (acc[4*g +: 4]),
            .b  (a_ext[4*g +: 4]),
            .ci (cy[g]),
            .s  (sum[4*g +: 4]),
            .co (cy[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = bus.in_valid ? (in_bad ? DONE : SHIFT) : IDLE;
            SHIFT: nxt = cur_dig != '0 ? ADD : (last_dig ? DONE : SHIFT);
            ADD:   nxt = rep != 4'd1 ? ADD : (last_dig ? DONE : SHIFT);
            DONE:  nxt = bus.out_ready ? IDLE : DONE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc     <= '0;
            rep     <= '0;
            dig_idx <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_q     <= bus.a_bcd;
                    b_q     <= bus.b_bcd;
                    acc     <= '0;
                    rep     <= '0;
                    dig_idx <= IW'(NDIG - 1);
                    err_q   <= in_bad;
                end
                SHIFT: begin
                    acc <= {acc[PW-5:0], 4'h0};
                    rep <= cur_dig;
                    if (cur_dig == '0 && !last_dig) dig_idx <= dig_idx - 1'b1;
                end
                ADD: begin
                    acc <= sum;
                    rep <= rep - 1'b1;
                    if (rep == 4'd1 && !last_dig) dig_idx <= dig_idx - 1'b1;
                end
                default: ;
            endcase
        end

    // the product can never exceed 2*NDIG digits, so the top carry must stay clear
    always_ff @(posedge clk)
        if (rst_n && state == ADD) assert (!cy_top);

    assign bus.in_ready  = state == IDLE;
    assign bus.busy      = state != IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.p_bcd     = acc;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_dec_mult_seq_ctrl.sv
// tb_dec_mult_seq_ctrl: scoreboard bench; expected product, err and latency are modelled at accept
module tb_dec_mult_seq_ctrl;
    import dec_mult_pkg::*;
    localparam int NDIG = 4;

    typedef struct {
        logic [31:0] p;
        logic        err;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int errors = 0;
    bit top_carry = 1'b0;
    exp_t exp_q[$];

    dec_mult_seq_ctrl_if #(.NDIG(NDIG)) bus ();

    dec_mult_seq_ctrl #(.NDIG(NDIG)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (rst_n && dut.state == ADD && dut.cy_top) top_carry = 1'b1;

    function automatic bit bad_in(input logic [15:0] a, input logic [15:0] b);
        for (int k = 0; k < NDIG; k++)
            if (a[4*k +: 4] > 4'd9 || b[4*k +: 4] > 4'd9) return 1'b1;
        return 1'b0;
    endfunction

    function automatic longint bcd2int(input logic [15:0] v);
        longint r = 0;
        for (int k = NDIG - 1; k >= 0; k--) r = r * 10 + longint'(v[4*k +: 4]);
        return r;
    endfunction

    function automatic logic [31:0] int2bcd(input longint x);
        logic [31:0] r = '0;
        for (int k = 0; k < 2*NDIG; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        bus.a_bcd = a;
        bus.b_bcd = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        e.err = bad_in(a, b);
        e.p = e.err ? 32'h0 : int2bcd(bcd2int(a) * bcd2int(b));
        e.lat = NDIG;
        for (int k = 0; k < NDIG; k++) e.lat += int'(b[4*k +: 4]);
        // a rejected operand pair shows its result in the cycle right after the accept edge
        if (e.err) e.lat = 0;
        exp_q.push_back(e);
        #1 bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat, output bit timeout);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        timeout = !bus.out_valid;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        bus.a_bcd = '0;
        bus.b_bcd = '0;
        #12;
        checks++;
        if ({bus.in_ready, bus.out_valid, bus.err, bus.busy} !== 4'b1000) begin
            errors++;
            $display("FAIL reset_flags got %b want 1000", {bus.in_ready, bus.out_valid, bus.err, bus.busy});
        end
        checks++;
        if (bus.p_bcd !== 32'h0) begin
            errors++;
            $display("FAIL reset_p got %h want 0", bus.p_bcd);
        end
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic test_product(input string name, input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        int lat;
        bit to;
        bus.out_ready = 1'b1;
        accept(a, b);
        wait_out(lat, to);
        e = exp_q.pop_front();
        checks++;
        if (to) begin
            errors++;
            $display("FAIL %s_timeout no out_valid within 200 cycles", name);
        end else begin
            checks += 3;
            if (lat !== e.lat) begin
                errors++;
                $display("FAIL %s_latency got %0d want %0d", name, lat, e.lat);
            end
            if (bus.p_bcd !== e.p) begin
                errors++;
                $display("FAIL %s_p got %h want %h", name, bus.p_bcd, e.p);
            end
            if (bus.err !== e.err) begin
                errors++;
                $display("FAIL %s_err got %b want %b", name, bus.err, e.err);
            end
        end
        @(posedge clk);
        #1 checks++;
        if (!bus.in_ready || bus.out_valid || bus.busy) begin
            errors++;
            $display("FAIL %s_release got rdy=%b ov=%b busy=%b want 1 0 0", name, bus.in_ready, bus.out_valid, bus.busy);
        end
    endtask

    task automatic test_max_operands();
        top_carry = 1'b0;
        test_product("max", 16'h9999, 16'h9999);
        checks++;
        if (top_carry !== 1'b0) begin
            errors++;
            $display("FAIL max_top_carry got %b want 0", top_carry);
        end
    endtask

    task automatic test_back_to_back();
        test_product("bad_digit", 16'h12A4, 16'h0003);
        test_product("after_bad", 16'h0002, 16'h0003);
    endtask

    task automatic test_backpressure();
        exp_t e;
        int lat;
        bit to;
        bus.out_ready = 1'b0;
        accept(16'h0025, 16'h0004);
        wait_out(lat, to);
        e = exp_q.pop_front();
        checks++;
        if (to || lat !== e.lat) begin
            errors++;
            $display("FAIL bp_latency got %0d (timeout %b) want %0d", lat, to, e.lat);
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = c == 2;
            bus.a_bcd = 16'h1111;
            bus.b_bcd = 16'h0009;
            checks++;
            if (!bus.out_valid || bus.in_ready || bus.p_bcd !== e.p || bus.err !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold_%0d got ov=%b rdy=%b p=%h err=%b want 1 0 %h 0", c, bus.out_valid, bus.in_ready, bus.p_bcd, bus.err, e.p);
            end
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1 checks++;
        if (bus.out_valid || !bus.in_ready) begin
            errors++;
            $display("FAIL bp_release got ov=%b rdy=%b want 0 1", bus.out_valid, bus.in_ready);
        end
        @(posedge clk);
        #1 checks++;
        if (bus.busy !== 1'b0 || bus.p_bcd !== e.p) begin
            errors++;
            $display("FAIL bp_no_capture got busy=%b p=%h want 0 %h", bus.busy, bus.p_bcd, e.p);
        end
    endtask

    task automatic test_reset_mid_op();
        bus.out_ready = 1'b1;
        accept(16'h9999, 16'h9999);
        repeat (12) @(posedge clk);
        #2 checks++;
        if (dut.state !== ADD) begin
            errors++;
            $display("FAIL rst_mid_state got %0d want ADD", dut.state);
        end
        rst_n = 1'b0;
        #1 checks += 2;
        if ({bus.in_ready, bus.out_valid, bus.err, bus.busy} !== 4'b1000) begin
            errors++;
            $display("FAIL rst_mid_flags got %b want 1000", {bus.in_ready, bus.out_valid, bus.err, bus.busy});
        end
        if (bus.p_bcd !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_p got %h want 0", bus.p_bcd);
        end
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        test_product("after_rst", 16'h0003, 16'h0003);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_product("basic", 16'h1234, 16'h5678);
        test_max_operands();
        test_product("b_zero", 16'h4321, 16'h0000);
        test_product("a_zero", 16'h0000, 16'h0001);
        test_back_to_back();
        test_backpressure();
        test_reset_mid_op();
        test_product("mixed", 16'h0907, 16'h3050);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
